// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter feeding a single-entry registered grant slot that carries
// both the one-hot grant and its binary index behind a valid/ready handshake.
module rr_grant_encoder #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [NUM_REQ-1:0]   gnt_onehot_o,
    output logic [IDX_WIDTH-1:0] gnt_idx_o
);

    logic                 r_valid;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [IDX_WIDTH-1:0] r_ptr;

    logic                 w_load;
    logic                 w_found;
    logic [IDX_WIDTH-1:0] w_win;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [IDX_WIDTH-1:0] w_ptr_nxt;

    assign w_load = !r_valid || ready_i;

    // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IDX_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_win_oh  = NUM_REQ'(1) << w_win;
    // Explicit wrap keeps non-power-of-two sizes in range; NUM_REQ=1 stays at 0.
    assign w_ptr_nxt = (w_win == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    assign ack_o = (w_load && w_found && !rst_i) ? w_win_oh : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            r_gnt   <= w_found ? w_win_oh : '0;
            r_idx   <= w_found ? w_win : '0;
            if (w_found) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign valid_o      = r_valid;
    assign gnt_onehot_o = r_gnt;
    assign gnt_idx_o    = r_idx;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder at NUM_REQ = 8, 5 and 1, driven by
// directed scenarios followed by randomized protocol-compliant traffic.
module tb_rr_grant_encoder;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] req8 = '0, ack8, gnt8;
    logic [2:0] idx8;
    logic       ready8 = 1'b0, valid8;
    logic [4:0] req5 = '0, ack5, gnt5;
    logic [2:0] idx5;
    logic       ready5 = 1'b0, valid5;
    logic [0:0] req1 = '0, ack1, gnt1;
    logic [0:0] idx1;
    logic       ready1 = 1'b0, valid1;

    rr_grant_encoder #(.NUM_REQ(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req8), .ack_o(ack8), .valid_o(valid8),
        .ready_i(ready8), .gnt_onehot_o(gnt8), .gnt_idx_o(idx8));
    rr_grant_encoder #(.NUM_REQ(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req5), .ack_o(ack5), .valid_o(valid5),
        .ready_i(ready5), .gnt_onehot_o(gnt5), .gnt_idx_o(idx5));
    rr_grant_encoder #(.NUM_REQ(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req1), .ack_o(ack1), .valid_o(valid1),
        .ready_i(ready1), .gnt_onehot_o(gnt1), .gnt_idx_o(idx1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after p, wrapping modulo n.
    function automatic int rr_win(input logic [7:0] r, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            if (r[(p + i) % n]) return (p + i) % n;
        end
        return -1;
    endfunction

    // Expected grants (binary index) awaiting transfer, per instance.
    int q8[$];
    int q5[$];
    int q1[$];
    int p8 = 0, p5 = 0;
    bit m8v = 0, m5v = 0, m1v = 0;
    logic [7:0] s_ack8 = '0;
    logic [4:0] s_ack5 = '0;
    logic [0:0] s_ack1 = '0;
    bit s_rst = 1'b1;
    int n1_acks = 0, n1_xfers = 0;

    // Reference models: advance on each clock edge from the inputs held across it.
    initial forever begin
        int w8, w5, w1;
        bit ld8, ld5, ld1;
        @(posedge clk or posedge rst_i);
        if (rst_i) begin
            q8.delete(); q5.delete(); q1.delete();
            p8 = 0; p5 = 0;
            m8v = 0; m5v = 0; m1v = 0;
        end else begin
            w8 = rr_win(req8, p8, 8);
            w5 = rr_win({3'b000, req5}, p5, 5);
            w1 = rr_win({7'b0, req1}, 0, 1);
            ld8 = !m8v || ready8;
            ld5 = !m5v || ready5;
            ld1 = !m1v || ready1;
            if (!s_rst) begin
                chk("ack8", 32'(s_ack8), (ld8 && w8 >= 0) ? (1 << w8) : 0);
                chk("ack5", 32'(s_ack5), (ld5 && w5 >= 0) ? (1 << w5) : 0);
                chk("ack1", 32'(s_ack1), (ld1 && w1 >= 0) ? 1 : 0);
            end
            if (ld8) begin
                m8v = (w8 >= 0);
                if (w8 >= 0) begin q8.push_back(w8); p8 = (w8 + 1) % 8; end
            end
            if (ld5) begin
                m5v = (w5 >= 0);
                if (w5 >= 0) begin q5.push_back(w5); p5 = (w5 + 1) % 5; end
            end
            if (ld1) begin
                m1v = (w1 >= 0);
                if (w1 >= 0) q1.push_back(w1);
            end
        end
    end

    // Monitor: samples outputs mid-cycle, compares against queue heads, pops on transfer.
    initial forever begin
        @(negedge clk);
        s_rst  = rst_i;
        s_ack8 = ack8;
        s_ack5 = ack5;
        s_ack1 = ack1;
        if (rst_i) begin
            chk("rst_valid8", 32'(valid8), 0);
            chk("rst_gnt8", 32'(gnt8), 0);
            chk("rst_idx8", 32'(idx8), 0);
            chk("rst_ack8", 32'(ack8), 0);
            chk("rst_valid5", 32'(valid5), 0);
            chk("rst_valid1", 32'(valid1), 0);
        end else begin
            if (ack1 == 1'b1) n1_acks++;
            chk("valid8", 32'(valid8), 32'(q8.size() != 0));
            if (q8.size() != 0) begin
                chk("idx8", 32'(idx8), q8[0]);
                chk("gnt8", 32'(gnt8), 1 << q8[0]);
                if (ready8) void'(q8.pop_front());
            end else begin
                chk("idle_gnt8", 32'(gnt8), 0);
                chk("idle_idx8", 32'(idx8), 0);
            end
            chk("ack8_onehot0", 32'($onehot0(ack8)), 1);

            chk("valid5", 32'(valid5), 32'(q5.size() != 0));
            if (q5.size() != 0) begin
                chk("idx5", 32'(idx5), q5[0]);
                chk("gnt5", 32'(gnt5), 1 << q5[0]);
                if (ready5) void'(q5.pop_front());
            end else begin
                chk("idle_gnt5", 32'(gnt5), 0);
                chk("idle_idx5", 32'(idx5), 0);
            end

            chk("valid1", 32'(valid1), 32'(q1.size() != 0));
            chk("idx1", 32'(idx1), 0);
            chk("gnt1", 32'(gnt1), 32'(q1.size() != 0));
            if (q1.size() != 0 && ready1) begin
                void'(q1.pop_front());
            end
            if (valid1 && ready1) n1_xfers++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        int prev;
        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;

        // Single request from reset.
        req8 = 8'h10; ready8 = 1'b1;
        #2 chk("single_ack", 32'(ack8), 32'h10);
        step();
        req8 = 8'h00;
        #2;
        chk("single_valid", 32'(valid8), 1);
        chk("single_gnt", 32'(gnt8), 32'h10);
        chk("single_idx", 32'(idx8), 4);
        step();
        #2 chk("single_drained", 32'(valid8), 0);

        // Full rotation with all requests held; pointer sits at 5 after the single grant.
        req8 = 8'hFF;
        step();
        chk("rot_first", 32'(idx8), 5);
        prev = int'(idx8);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("rot_valid", 32'(valid8), 1);
            chk("rot_next", 32'(idx8), (prev + 1) % 8);
            prev = int'(idx8);
        end
        req8 = 8'h00;
        step();
        step();

        // Backpressure holds the grant and suppresses ack.
        do_reset();
        req8 = 8'h0C; ready8 = 1'b0;
        #2 chk("bp_ack_first", 32'(ack8), 32'h04);
        step();
        req8 = 8'h08;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("bp_idx_hold", 32'(idx8), 2);
            chk("bp_ack_zero", 32'(ack8), 0);
            step();
        end
        ready8 = 1'b1;
        #2 chk("bp_ack_release", 32'(ack8), 32'h08);
        step();
        req8 = 8'h00;
        chk("bp_next_idx", 32'(idx8), 3);
        step();
        step();

        // Asynchronous reset while a grant is held.
        do_reset();
        req8 = 8'hA0; ready8 = 1'b0;
        #2 chk("rr_ack_pre", 32'(ack8), 32'h20);
        step();
        req8 = 8'h80;
        chk("rr_idx_pre", 32'(idx8), 5);
        #2 rst_i = 1'b1;
        #1;
        chk("rr_async_valid", 32'(valid8), 0);
        chk("rr_async_idx", 32'(idx8), 0);
        chk("rr_async_gnt", 32'(gnt8), 0);
        chk("rr_async_ack", 32'(ack8), 0);
        step();
        rst_i = 1'b0;
        req8 = 8'hA0; ready8 = 1'b1;
        #2 chk("rr_ack_post", 32'(ack8), 32'h20);
        step();
        req8 = 8'h80;
        chk("rr_idx_post", 32'(idx8), 5);
        step();
        req8 = 8'h00;
        step();
        step();

        // Non-power-of-two wrap: 0,4,0,4...
        do_reset();
        req5 = 5'b10001; ready5 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("wrap5_idx", 32'(idx5), (k % 2) * 4);
        end
        req5 = '0;
        step();
        step();

        // Randomized protocol-compliant traffic on all three instances.
        for (int k = 0; k < 600; k++) begin
            req8 = (req8 & ~s_ack8) | (8'($urandom) & 8'($urandom));
            req5 = (req5 & ~s_ack5) | (5'($urandom) & 5'($urandom));
            req1 = (req1 & ~s_ack1) | 1'($urandom);
            ready8 = ($urandom_range(0, 3) != 0);
            ready5 = ($urandom_range(0, 3) != 0);
            ready1 = ($urandom_range(0, 1) != 0);
            step();
        end
        req8 = '0; req5 = '0; req1 = '0;
        ready8 = 1'b1; ready5 = 1'b1; ready1 = 1'b1;
        repeat (4) step();
        chk("n1_grants_eq_xfers", 32'(n1_acks), 32'(n1_xfers));
        chk("q8_empty", 32'(q8.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
# rr_grant_encoder

Round-robin arbiter that selects one of `NUM_REQ` requesters, acknowledges it with a one-hot pulse and places the winner into a single-entry output register. The register holds both the one-hot grant and its binary index, and presents them over a valid/ready handshake. It sits directly upstream of the one-hot-to-binary encoder in the request-steering path. It also supplies the binary index itself, so downstream consumers can use either form from one registered, aligned source.

## Interface
- `NUM_REQ`, default 8: number of requesters; any value ≥ 1.
- `IDX_WIDTH`, default `NUM_REQ == 1 ? 1 : $clog2(NUM_REQ)`: width of binary index.

- `clk_i` input, 1: clock, rising-edge.
- `rst_i` input, 1: asynchronous active-high reset.
- `req_i` input, `NUM_REQ`: request vector; a requester holds its bit high until it sees its `ack_o` bit.
- `ack_o` output, `NUM_REQ`: one-hot (or zero), combinational; the bit is high in the cycle the request is captured.
- `valid_o` output, 1: output register holds a grant.
- `ready_i` input, 1: downstream accepts the grant this cycle.
- `gnt_onehot_o` output, `NUM_REQ`: registered one-hot grant; all zero when `valid_o` = 0.
- `gnt_idx_o` output, `IDX_WIDTH`: registered binary index of `gnt_onehot_o`; zero when `valid_o` = 0.

## Operation
- **State.**
  - Priority pointer `ptr` in `0..NUM_REQ-1`.
  - Output register: `valid_o`, `gnt_onehot_o`, `gnt_idx_o`.
- **Load enable.** `load = !valid_o || ready_i`; the slot is empty or is being drained this cycle.
- **Arbitration (combinational).** Winner = first set bit of `req_i` scanning from `ptr` upward, wrapping from `NUM_REQ-1` to 0.
- **Acknowledge.** `ack_o` = one-hot winner when `load` and `|req_i`; otherwise 0.
- **Capture.** On a cycle with `load`:
  - If a winner k exists: `valid_o`←1, `gnt_onehot_o`←(1<<k), `gnt_idx_o`←k, `ptr`←(k+1) mod `NUM_REQ`.
  - If no winner: `valid_o`←0, `gnt_onehot_o`←0, `gnt_idx_o`←0, `ptr` unchanged.
- **Backpressure.** When `!load` (`valid_o`=1, `ready_i`=0):
  - Output register and `ptr` hold.
  - `ack_o`=0.
  - Requests are not consumed.
- **Pointer wrap.** Uses modulo `NUM_REQ`, not power-of-two truncation. For `NUM_REQ`=5, k=4 gives `ptr`=0.
- **Index encoding.** `gnt_idx_o` is always exactly the binary encoding of `gnt_onehot_o`, which is zero-extended to `IDX_WIDTH`.
- **Single requester (`NUM_REQ`=1).**
  - `ptr` is a constant 0.
  - `gnt_idx_o` is always 0.
  - Handshake behaviour is unchanged.
- **Out-of-protocol input.** Dropping `req_i` before `ack_o` is a requester protocol violation. The arbiter simply re-evaluates each cycle and captures nothing stale.

## Timing
- **Reset values.** While `rst_i` is high, asynchronously: `ptr`=0, `valid_o`=0, `gnt_onehot_o`=0, `gnt_idx_o`=0.
  - `ack_o` is 0 in reset, because `req_i` is ignored while `rst_i` is asserted.
- **Latency.** Request present in cycle t with slot loadable: `ack_o` high in cycle t; `valid_o` and grant visible from cycle t+1.
- **Throughput.** One grant per cycle while `ready_i` is held high and requests are pending.
  - Back-to-back: a grant in cycle t+1 with `ready_i`=1 lets a new winner be acked in t+1 and appear in t+2.
- **Handshake transfer.** Occurs on the rising edge where `valid_o` && `ready_i`.
  - `valid_o` never drops without a transfer.
  - The grant is stable while stalled.
- **Simultaneous drain and request.** Drain and capture happen in the same edge, with no bubble.
- **Reset mid-operation.** Any held grant is discarded. `ptr` returns to 0. The first post-reset grant follows the reset priority (lowest index first).
- **Fairness.** With all requests continuously asserted, each requester is granted exactly once per `NUM_REQ` transfers.

## Test plan
- **Single request.** `NUM_REQ`=8; `req_i`=8'h10 for one cycle from reset, `ready_i`=1 → `ack_o`=8'h10 that cycle; next cycle `valid_o`=1, `gnt_onehot_o`=8'h10, `gnt_idx_o`=4; then `valid_o`=0.
- **Full rotation.** `req_i`=8'hFF held, `ready_i`=1 → `gnt_idx_o` sequence 0,1,…,7,0 on consecutive cycles with no bubbles; `ack_o` one-hot each cycle.
- **Backpressure.** `req_i`=8'h0C, `ready_i`=0 for 4 cycles after the first grant → `gnt_idx_o`=2 stable, `ack_o`=0 during the stall; raise `ready_i` → next grant `gnt_idx_o`=3.
- **Non-power-of-two wrap.** `NUM_REQ`=5; `req_i`=5'b10001 held, `ready_i`=1 → indices 0,4,0,4…; after the grant to 4, `ptr`=0; `gnt_idx_o` never exceeds 4.
- **Reset mid-operation.** Assert `rst_i` asynchronously mid-cycle while `valid_o`=1 and `gnt_idx_o`=5 → outputs zero immediately; after release with `req_i`=8'hA0 → first grant `gnt_idx_o`=5.
- **Degenerate width.** `NUM_REQ`=1; toggle `req_i` and `ready_i` randomly → `gnt_idx_o`=0 always; `ack_o` only when `req_i` && `load`; grant count equals transfer count.
